// File: rtl/uart_tx_dev_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// default base address, FSM state encoding and the divisor clamp helper.
package uart_tx_dev_pkg;

  // Register offsets, indexed by addr[3:2]
  localparam logic [1:0] UART_CTRL   = 2'd0;
  localparam logic [1:0] UART_STAT   = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;
  localparam logic [1:0] UART_TXDATA = 2'd3;

  // Default location of the block on the bridge
  localparam logic [31:0] UART_BASE = 32'h0000_7F30;

  // Transmitter frame states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Divisors below 2 cannot time a bit sensibly, so they run as 2
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/uart_tx_dev_sync_fifo.sv
// Small synchronous FIFO, reusable by the transmit and a future receive path.
// Handshake: push is honoured when the FIFO is not full, or when it is full
// but a pop is taken on the same edge; pop is honoured whenever not empty.
// dout always shows the head entry, so a pop consumes the value seen that cycle.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count guards reads
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register decode, 4-entry TX FIFO,
// frame FSM, bit timer and shift register. irq is a level "drained" request.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter logic [31:0] BASE        = UART_BASE,
  parameter int          DEPTH_LOG2  = 2,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq,
  output logic        txd
);

  uart_state_e         state;
  uart_state_e         state_nxt;
  logic                en;
  logic                ie;
  logic                ovf;
  logic [15:0]         div_reg;
  logic [15:0]         div_q;
  logic [15:0]         timer;
  logic [7:0]          shift;
  logic [2:0]          bit_idx;
  logic                timer_done;
  logic                busy;

  logic                sel;
  logic [1:0]          off;
  logic                wr_ctrl;
  logic                wr_div;
  logic                wr_txdata;

  logic                fifo_pop;
  logic [7:0]          fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;

  logic                unused_bits;
  assign unused_bits = ^{addr[1:0], wd[31:16]};

  assign sel       = (addr[31:4] == BASE[31:4]);
  assign off       = addr[3:2];
  assign wr_ctrl   = we && sel && (off == UART_CTRL);
  assign wr_div    = we && sel && (off == UART_DIV);
  assign wr_txdata = we && sel && (off == UART_TXDATA);

  assign timer_done = (timer == 16'd0);
  assign busy       = (state != ST_IDLE);
  assign irq        = ie && en && fifo_empty && !busy;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control/divisor registers and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      ovf     <= 1'b0;
      div_reg <= DEFAULT_DIV;
    end else begin
      if (wr_ctrl) begin
        en <= wd[0];
        ie <= wd[1];
      end
      if (wr_div) begin
        div_reg <= wd[15:0];
      end
      if (wr_ctrl) begin
        ovf <= 1'b0;
      end else if (wr_txdata && fifo_full && !fifo_pop) begin
        ovf <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state, FIFO pop and serial output
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    txd       = 1'b1;
    case (state)
      ST_IDLE: begin
        if (en && !fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        txd = 1'b0;
        if (timer_done) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        txd = shift[0];
        if (timer_done && (bit_idx == 3'd7)) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (timer_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bit timer, shift register and bit index; the divisor is frozen per frame
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= 16'd2;
      timer   <= 16'd0;
      shift   <= 8'd0;
      bit_idx <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            shift   <= fifo_dout;
            div_q   <= eff_div(div_reg);
            timer   <= eff_div(div_reg) - 16'd1;
            bit_idx <= 3'd0;
          end
        end
        ST_START: begin
          timer <= timer_done ? (div_q - 16'd1) : (timer - 16'd1);
        end
        ST_DATA: begin
          if (timer_done) begin
            timer   <= div_q - 16'd1;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        ST_STOP: begin
          if (!timer_done) timer <= timer - 16'd1;
        end
        default: timer <= 16'd0;
      endcase
    end
  end

  // Combinational read mux; unselected or undefined bits read as zero
  always_comb begin
    rd = 32'd0;
    if (sel) begin
      case (off)
        UART_CTRL: rd[1:0] = {ie, en};
        UART_STAT: begin
          rd[0] = busy;
          rd[1] = fifo_full;
          rd[2] = fifo_empty;
          rd[3] = ovf;
          rd[4 +: DEPTH_LOG2 + 1] = fifo_count;
        end
        UART_DIV:  rd[15:0] = div_reg;
        default:   rd = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Bench for uart_tx_dev: directed bus writes, a queue of expected frames and a
// serial monitor that decodes every txd frame and checks it against the queue.
module tb_uart_tx_dev;
  import uart_tx_dev_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_7F30;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;
  logic        txd;

  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  bit  mon_abort = 1'b0;

  // expected frame: {back_to_back, div, byte}
  logic [24:0] exp_q[$];

  uart_tx_dev #(
    .BASE        (BASE),
    .DEPTH_LOG2  (2),
    .DEFAULT_DIV (16'd16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq),
    .txd   (txd)
  );

  // clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wr_addr(input logic [31:0] a, input logic [31:0] data);
    addr = a;
    wd   = data;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] data);
    wr_addr(BASE + {28'd0, off, 2'b00}, data);
  endtask

  task automatic rd_raw_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    check(name, rd, exp);
  endtask

  task automatic rd_chk(input logic [1:0] off, input logic [31:0] exp, input string name);
    rd_raw_chk(BASE + {28'd0, off, 2'b00}, exp, name);
  endtask

  task automatic get_stat(output logic [31:0] v);
    addr = BASE + 32'h4;
    #1;
    v = rd;
  endtask

  task automatic push(input logic [7:0] b, input logic [15:0] div, input bit b2b);
    exp_q.push_back({b2b, div, b});
    wr(UART_TXDATA, {24'd0, b});
  endtask

  task automatic wait_idle(input int bound, input string name);
    logic [31:0] s;
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      get_stat(s);
      if (!s[0] && s[2]) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: transmitter not idle after %0d cycles", name, bound);
    end
    repeat (2) @(negedge clk);
  endtask

  // serial monitor: decode each frame and compare with the expected queue
  initial begin : monitor
    logic        prev;
    logic [24:0] ent;
    logic [7:0]  got_b;
    logic        expb;
    int          div, seg, mism, start_cyc, prev_start, prev_div;
    bit          have_prev, aborted;
    prev = 1'b1;
    have_prev = 1'b0;
    prev_start = 0;
    prev_div = 0;
    forever begin
      @(negedge clk);
      if (!mon_abort && prev && !txd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: txd fell at cycle %0d, required no frame", cyc);
        end else begin
          ent = exp_q.pop_front();
          div = int'(ent[23:8]);
          start_cyc = cyc;
          if (ent[24] && have_prev)
            check("frame_spacing", 32'(start_cyc - prev_start), 32'(10 * prev_div + 1));
          mism = 0;
          got_b = 8'd0;
          aborted = 1'b0;
          for (int k = 1; k < 10 * div; k++) begin
            @(negedge clk);
            if (mon_abort) begin
              aborted = 1'b1;
              break;
            end
            seg = k / div;
            if (seg == 0)      expb = 1'b0;
            else if (seg == 9) expb = 1'b1;
            else               expb = ent[seg - 1];
            if (txd !== expb) mism++;
            if (seg >= 1 && seg <= 8 && (k % div) == div / 2) got_b[seg - 1] = txd;
          end
          if (!aborted) begin
            check("frame_shape_errs", 32'(mism), 32'd0);
            check("frame_byte", {24'd0, got_b}, {24'd0, ent[7:0]});
            prev_start = start_cyc;
            prev_div = div;
            have_prev = 1'b1;
          end else begin
            have_prev = 1'b0;
          end
        end
      end
      prev = txd;
    end
  end

  // directed stimulus
  initial begin : stim
    logic [31:0] s;
    int busy_cnt, irq_bad;
    bit seen, rose;
    reset = 1'b1;
    we    = 1'b0;
    addr  = 32'd0;
    wd    = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    rd_chk(UART_CTRL, 32'h0, "rst_ctrl");
    rd_chk(UART_STAT, 32'h4, "rst_stat");
    rd_chk(UART_DIV, 32'd16, "rst_div");
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // basic frame at div 4; BUSY spans exactly one frame
    wr(UART_DIV, 32'd4);
    wr(UART_CTRL, 32'd1);
    push(8'hA5, 16'd4, 1'b0);
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      get_stat(s);
      if (s[0]) begin
        busy_cnt++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
      @(negedge clk);
    end
    check("busy_cycles", 32'(busy_cnt), 32'd40);
    wait_idle(200, "idle_after_a5");

    // overflow with EN off, then four back-to-back frames
    wr(UART_CTRL, 32'd0);
    push(8'h11, 16'd4, 1'b0);
    push(8'h22, 16'd4, 1'b1);
    push(8'hC3, 16'd4, 1'b1);
    push(8'h7E, 16'd4, 1'b1);
    wr(UART_TXDATA, 32'h99);
    rd_chk(UART_STAT, 32'h4A, "ovf_full_stat");
    wr(UART_CTRL, 32'd1);
    rd_chk(UART_STAT, 32'h42, "ovf_cleared_stat");
    wait_idle(1000, "idle_after_b2b");

    // interrupt: drained level, dropped by a push, back after the frame
    wr(UART_CTRL, 32'd3);
    check("irq_drained", {31'd0, irq}, 32'd1);
    push(8'h00, 16'd4, 1'b0);
    check("irq_after_push", {31'd0, irq}, 32'd0);
    irq_bad = 0;
    seen = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 200; i++) begin
      get_stat(s);
      if (s[0]) begin
        seen = 1'b1;
        if (irq) irq_bad++;
      end else if (seen) begin
        rose = irq;
        break;
      end
      @(negedge clk);
    end
    check("irq_during_busy", 32'(irq_bad), 32'd0);
    check("irq_rise", {31'd0, rose}, 32'd1);
    wr(UART_CTRL, 32'd1);
    check("irq_ie_off", {31'd0, irq}, 32'd0);
    wait_idle(200, "idle_after_irq");

    // push and pop on the same edge with a full FIFO; DIV change mid-frame
    wr(UART_CTRL, 32'd0);
    push(8'h3C, 16'd4, 1'b0);
    push(8'h81, 16'd8, 1'b1);
    push(8'h5A, 16'd8, 1'b1);
    push(8'hFF, 16'd8, 1'b1);
    wr(UART_CTRL, 32'd1);
    push(8'h01, 16'd8, 1'b1);
    rd_chk(UART_STAT, 32'h43, "full_push_pop_stat");
    wr(UART_DIV, 32'd8);
    rd_chk(UART_DIV, 32'd8, "div_readback_8");
    wait_idle(3000, "idle_after_div_change");

    // DIV=0 clamps to 2-cycle bits, stored value reads back unchanged
    wr(UART_DIV, 32'd0);
    rd_chk(UART_DIV, 32'd0, "div_readback_0");
    push(8'h6E, 16'd2, 1'b0);
    wait_idle(200, "idle_after_div0");

    // out-of-range addresses: reads are zero, writes do nothing
    wr_addr(BASE + 32'h10, 32'h0);
    wr_addr(BASE - 32'h4, 32'h0);
    wr_addr(BASE + 32'h1C, 32'h55);
    rd_raw_chk(BASE + 32'h10, 32'h0, "oor_rd_ctrl_alias");
    rd_raw_chk(BASE + 32'h14, 32'h0, "oor_rd_stat_alias");
    rd_chk(UART_CTRL, 32'h1, "oor_ctrl_kept");
    rd_chk(UART_STAT, 32'h4, "oor_no_push");
    rd_chk(UART_TXDATA, 32'h0, "txdata_reads_zero");

    // reset in the middle of DATA discards the frame and the queue
    wr(UART_DIV, 32'd4);
    push(8'hA1, 16'd4, 1'b0);
    push(8'hB2, 16'd4, 1'b1);
    push(8'hC3, 16'd4, 1'b1);
    repeat (10) @(negedge clk);
    mon_abort = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_txd", {31'd0, txd}, 32'd1);
    rd_chk(UART_STAT, 32'h4, "reset_stat");
    rd_chk(UART_CTRL, 32'h0, "reset_ctrl");
    rd_chk(UART_DIV, 32'd16, "reset_div");
    exp_q.delete();
    mon_abort = 1'b0;
    wr(UART_CTRL, 32'd1);
    repeat (60) @(negedge clk);
    rd_chk(UART_STAT, 32'h4, "no_stale_bytes");

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
